qproc_mem_xfer_ctrl: RTL and testbench

Sequencer and arbiter for the tProc single-port memory. It executes PS-initiated block transfers of `mem_len_i` words starting at `mem_addr_i`, one word at a time. Data moves through the AXI register data words (MEM_DT_I / MEM_DT_O). The block shares the memory port with the core, and the core always has priority. It sits in the c_clk domain after the PS→core control synchronisers, so command inputs arrive as one-cycle pulses.

---
 rtl/qproc_mem_xfer_ctrl.sv | 156 +++++++++++++++
 tb/tb_qproc_mem_xfer_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qproc_mem_xfer_ctrl.sv
// Block-transfer sequencer sharing the tProc single-port memory with the core.
// The core always wins the port; PS transfers move one word at a time.
module qproc_mem_xfer_ctrl #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 32
) (
  input  logic          c_clk_i,
  input  logic          c_rst_i,
  input  logic          cmd_start_i,
  input  logic          cmd_abort_i,
  input  logic          cmd_dir_i,
  input  logic [AW-1:0] mem_addr_i,
  input  logic [AW-1:0] mem_len_i,
  input  logic [DW-1:0] wdt_i,
  input  logic          wdt_vld_i,
  output logic [DW-1:0] rdt_o,
  output logic          rdt_vld_o,
  input  logic          rdt_ack_i,
  input  logic          core_req_i,
  input  logic          core_we_i,
  input  logic [AW-1:0] core_addr_i,
  input  logic [DW-1:0] core_wdt_i,
  output logic          core_gnt_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdt_o,
  input  logic [DW-1:0] mem_rdt_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [AW-1:0] cnt_o
);

  typedef enum logic [2:0] {
    IDLE, WR_WAIT, WR_ISSUE, RD_ISSUE, RD_CAPT, RD_HOLD, DONE
  } state_t;

  state_t        state;
  logic [AW-1:0] addr;
  logic [DW-1:0] wbuf;
  logic [AW-1:0] addr_inc;
  logic [AW-1:0] cnt_dec;

  assign addr_inc   = addr + AW'(1);
  assign cnt_dec    = cnt_o - AW'(1);
  assign core_gnt_o = core_req_i;
  assign busy_o     = (state != IDLE) && (state != DONE);

  // Sequencer; abort overrides every other event of the cycle.
  always_ff @(posedge c_clk_i or posedge c_rst_i) begin
    if (c_rst_i) begin
      state     <= IDLE;
      addr      <= '0;
      cnt_o     <= '0;
      wbuf      <= '0;
      rdt_o     <= '0;
      rdt_vld_o <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (cmd_abort_i && state != IDLE) begin
        state     <= IDLE;
        rdt_vld_o <= 1'b0;
        err_o     <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (cmd_start_i) begin
              addr  <= mem_addr_i;
              cnt_o <= mem_len_i;
              err_o <= 1'b0;
              if (mem_len_i == '0) begin
                state  <= DONE;
                done_o <= 1'b1;
              end else if (cmd_dir_i) begin
                state <= WR_WAIT;
              end else begin
                state <= RD_ISSUE;
              end
            end
          end
          WR_WAIT: begin
            if (wdt_vld_i) begin
              wbuf  <= wdt_i;
              state <= WR_ISSUE;
            end
          end
          WR_ISSUE: begin
            if (!core_req_i) begin
              addr  <= addr_inc;
              cnt_o <= cnt_dec;
              if (cnt_dec == '0) begin
                state  <= DONE;
                done_o <= 1'b1;
              end else begin
                state <= WR_WAIT;
              end
            end
          end
          RD_ISSUE: begin
            if (!core_req_i) state <= RD_CAPT;
          end
          RD_CAPT: begin
            rdt_o     <= mem_rdt_i;
            rdt_vld_o <= 1'b1;
            state     <= RD_HOLD;
          end
          RD_HOLD: begin
            if (rdt_ack_i) begin
              rdt_vld_o <= 1'b0;
              addr      <= addr_inc;
              cnt_o     <= cnt_dec;
              if (cnt_dec == '0) begin
                state  <= DONE;
                done_o <= 1'b1;
              end else begin
                state <= RD_ISSUE;
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
      // A word arriving while the buffer cannot take it is dropped and flagged.
      if (wdt_vld_i && state != WR_WAIT) err_o <= 1'b1;
    end
  end

  // Port mux: core first; an abort cycle suppresses the controller's access.
  always_comb begin
    mem_en_o   = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_wdt_o  = '0;
    if (core_req_i) begin
      mem_en_o   = 1'b1;
      mem_we_o   = core_we_i;
      mem_addr_o = core_addr_i;
      mem_wdt_o  = core_wdt_i;
    end else if (!cmd_abort_i) begin
      if (state == WR_ISSUE) begin
        mem_en_o   = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = addr;
        mem_wdt_o  = wbuf;
      end else if (state == RD_ISSUE) begin
        mem_en_o   = 1'b1;
        mem_addr_o = addr;
      end
    end
  end

endmodule

// File: tb/tb_qproc_mem_xfer_ctrl.sv
// Scoreboard bench for qproc_mem_xfer_ctrl: expected words are queued at start,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_qproc_mem_xfer_ctrl;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_start = 1'b0, cmd_abort = 1'b0, cmd_dir = 1'b0;
  logic [AW-1:0] mem_addr = '0, mem_len = '0;
  logic [DW-1:0] wdt = '0;
  logic          wdt_vld = 1'b0, rdt_ack = 1'b0;
  logic          core_req = 1'b0, core_we = 1'b0;
  logic [AW-1:0] core_addr = '0;
  logic [DW-1:0] core_wdt = '0;
  logic [DW-1:0] rdt_o, mem_wdt_o;
  logic          rdt_vld_o, core_gnt_o, mem_en_o, mem_we_o, busy_o, done_o, err_o;
  logic [AW-1:0] mem_addr_o, cnt_o;
  logic [DW-1:0] mem_rdt;

  logic [DW-1:0] mem     [0:65535];
  logic [DW-1:0] ref_mem [0:65535];
  logic [DW-1:0] exp_rd[$];
  wr_t           exp_wr[$];
  logic [DW-1:0] wq[$];
  wr_t           mon_e;
  logic [DW-1:0] mon_d;

  int pass_cnt = 0, total_cnt = 0, done_cnt = 0, wr_seen = 0, ctl_acc = 0;
  bit prev_vld = 1'b0;

  always #5 clk = ~clk;

  qproc_mem_xfer_ctrl #(.AW(AW), .DW(DW)) dut (
    .c_clk_i(clk), .c_rst_i(rst),
    .cmd_start_i(cmd_start), .cmd_abort_i(cmd_abort), .cmd_dir_i(cmd_dir),
    .mem_addr_i(mem_addr), .mem_len_i(mem_len),
    .wdt_i(wdt), .wdt_vld_i(wdt_vld),
    .rdt_o(rdt_o), .rdt_vld_o(rdt_vld_o), .rdt_ack_i(rdt_ack),
    .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr),
    .core_wdt_i(core_wdt), .core_gnt_o(core_gnt_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdt_o(mem_wdt_o), .mem_rdt_i(mem_rdt),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .cnt_o(cnt_o)
  );

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    if (a >= 16'h0010 && a < 16'h0014) return 32'h0000_00A0 + 32'(a - 16'h0010);
    return {a ^ 16'h5A5A, a};
  endfunction

  // Single-port memory model, read data one cycle after the access.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 65536; i++) mem[i] <= init_word(16'(i));
      mem_rdt <= '0;
    end else if (mem_en_o) begin
      if (mem_we_o) mem[mem_addr_o] <= mem_wdt_o;
      else          mem_rdt <= mem[mem_addr_o];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: arbitration, controller writes, read words and done pulses.
  always @(negedge clk) begin
    if (!rst) begin
      chk("core_gnt", 64'(core_gnt_o), 64'(core_req));
      if (core_req) begin
        chk("core_mux_en", 64'(mem_en_o), 64'(1));
        chk("core_mux_we", 64'(mem_we_o), 64'(core_we));
        chk("core_mux_addr", 64'(mem_addr_o), 64'(core_addr));
        if (core_we) chk("core_mux_wdt", 64'(mem_wdt_o), 64'(core_wdt));
      end else if (mem_en_o) begin
        ctl_acc++;
        if (mem_we_o) begin
          wr_seen++;
          if (exp_wr.size() == 0) chk("unexpected_write", 64'(mem_addr_o), 64'hFFFF_FFFF_FFFF_FFFF);
          else begin
            mon_e = exp_wr.pop_front();
            chk("write_addr", 64'(mem_addr_o), 64'(mon_e.a));
            chk("write_data", 64'(mem_wdt_o), 64'(mon_e.d));
          end
        end
      end
      if (rdt_vld_o && !prev_vld) begin
        if (exp_rd.size() == 0) chk("unexpected_read", 64'(rdt_o), 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          mon_d = exp_rd.pop_front();
          chk("read_data", 64'(rdt_o), 64'(mon_d));
        end
      end
      prev_vld = rdt_vld_o;
      if (done_o) done_cnt++;
    end
  end

  // Reference transfer: expectations from ref_mem and the address/length rules.
  task automatic run_xfer(input bit dir, input logic [AW-1:0] a, input logic [AW-1:0] len,
                          input int core_pct, input int ack_lat, input bit poke);
    logic [DW-1:0] ws[$];
    logic [DW-1:0] w;
    logic [AW-1:0] ai, snap;
    int d0, w0, a0, sent, lat, cyc;
    bit poked;
    d0 = done_cnt; w0 = wr_seen; a0 = ctl_acc;
    sent = 0; lat = 0; cyc = 0; poked = 1'b0; snap = '0;
    for (int i = 0; i < int'(len); i++) begin
      ai = a + 16'(i);
      if (dir) begin
        w = (wq.size() > 0) ? wq.pop_front() : $urandom;
        ws.push_back(w);
        exp_wr.push_back('{a: ai, d: w});
        ref_mem[ai] = w;
      end else begin
        exp_rd.push_back(ref_mem[ai]);
      end
    end
    cmd_dir = dir; mem_addr = a; mem_len = len; cmd_start = 1'b1;
    tick;
    cmd_start = 1'b0;
    chk("start_cnt", 64'(cnt_o), 64'(len));
    chk("start_busy", 64'(busy_o), 64'(len != 0));
    chk("start_err", 64'(err_o), 64'(0));
    if (len == 0) chk("zero_done", 64'(done_o), 64'(1));
    while (done_cnt == d0 && cyc < 3000) begin
      wdt_vld = 1'b0; rdt_ack = 1'b0;
      if (cmd_start) begin
        cmd_start = 1'b0;
        chk("busy_start_cnt", 64'(cnt_o), 64'(snap));
      end
      core_req = ($urandom_range(99) < core_pct);
      core_we = 1'b0; core_addr = 16'($urandom);
      if (dir && sent < int'(len) && (wr_seen - w0) == sent) begin
        wdt = ws[sent]; wdt_vld = 1'b1; sent++;
      end
      if (!dir && rdt_vld_o) begin
        if (poke && !poked && lat == 1) begin
          poked = 1'b1; snap = cnt_o;
          cmd_start = 1'b1; cmd_dir = ~dir; mem_addr = ~a; mem_len = 16'h0007;
        end
        if (lat >= ack_lat) begin rdt_ack = 1'b1; lat = 0; end
        else lat++;
      end
      tick;
      cyc++;
    end
    wdt_vld = 1'b0; rdt_ack = 1'b0; core_req = 1'b0; cmd_start = 1'b0;
    chk("xfer_done", 64'(done_cnt - d0), 64'(1));
    chk("end_cnt", 64'(cnt_o), 64'(0));
    chk("end_err", 64'(err_o), 64'(0));
    chk("end_busy", 64'(busy_o), 64'(0));
    if (dir) chk("wr_count", 64'(wr_seen - w0), 64'(len));
    else     chk("rd_left", 64'(exp_rd.size()), 64'(0));
    if (len == 0) chk("zero_no_access", 64'(ctl_acc - a0), 64'(0));
    if (poke) chk("poke_done", 64'(poked), 64'(1));
  endtask

  initial begin
    int n, d0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_word(16'(i));
    repeat (3) tick;
    chk("rst_rdt", 64'(rdt_o), 64'(0));
    chk("rst_vld", 64'(rdt_vld_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_done", 64'(done_o), 64'(0));
    chk("rst_err", 64'(err_o), 64'(0));
    chk("rst_cnt", 64'(cnt_o), 64'(0));
    chk("rst_mem_en", 64'(mem_en_o), 64'(0));
    rst = 1'b0;
    tick;
    chk("idle_mem_en", 64'(mem_en_o), 64'(0));

    // Read 4 words from 0x10, ack 2 cycles after valid.
    run_xfer(1'b0, 16'h0010, 16'd4, 0, 2, 1'b0);

    // Write 3 words across the address wrap.
    wq = '{32'h11, 32'h22, 32'h33};
    run_xfer(1'b1, 16'hFFFE, 16'd3, 0, 0, 1'b0);
    chk("wrap_mem_fffe", 64'(mem[16'hFFFE]), 64'h11);
    chk("wrap_mem_ffff", 64'(mem[16'hFFFF]), 64'h22);
    chk("wrap_mem_0000", 64'(mem[16'h0000]), 64'h33);

    // Core holds the port for 5 cycles of RD_ISSUE.
    d0 = done_cnt;
    exp_rd.push_back(ref_mem[16'h0020]);
    cmd_dir = 1'b0; mem_addr = 16'h0020; mem_len = 16'd1; cmd_start = 1'b1;
    tick;
    cmd_start = 1'b0; core_req = 1'b1; core_addr = 16'h1234;
    n = 0;
    while (!rdt_vld_o && n < 50) begin
      tick; n++;
      if (n == 5) core_req = 1'b0;
    end
    core_req = 1'b0;
    chk("contention_latency", 64'(n), 64'(7));
    rdt_ack = 1'b1; tick; rdt_ack = 1'b0;
    tick;
    chk("contention_done", 64'(done_cnt - d0), 64'(1));

    // Abort while holding a read word.
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) exp_rd.push_back(ref_mem[16'h0050 + 16'(i)]);
    cmd_dir = 1'b0; mem_addr = 16'h0050; mem_len = 16'd3; cmd_start = 1'b1;
    tick;
    cmd_start = 1'b0;
    n = 0;
    while (!rdt_vld_o && n < 20) begin tick; n++; end
    chk("abort_vld_seen", 64'(rdt_vld_o), 64'(1));
    cmd_abort = 1'b1; tick; cmd_abort = 1'b0;
    chk("abort_busy", 64'(busy_o), 64'(0));
    chk("abort_vld", 64'(rdt_vld_o), 64'(0));
    chk("abort_err", 64'(err_o), 64'(1));
    exp_rd.delete();
    tick; tick;
    chk("abort_no_done", 64'(done_cnt - d0), 64'(0));
    chk("abort_err_sticky", 64'(err_o), 64'(1));
    // Zero-length start clears the error and completes without access.
    run_xfer(1'b0, 16'h0060, 16'd0, 0, 0, 1'b0);

    // Overrun: second back-to-back word is dropped.
    d0 = done_cnt;
    exp_wr.push_back('{a: 16'h0300, d: 32'h1111_0000});
    exp_wr.push_back('{a: 16'h0301, d: 32'h3333_0002});
    ref_mem[16'h0300] = 32'h1111_0000; ref_mem[16'h0301] = 32'h3333_0002;
    cmd_dir = 1'b1; mem_addr = 16'h0300; mem_len = 16'd2; cmd_start = 1'b1;
    tick;
    cmd_start = 1'b0; wdt = 32'h1111_0000; wdt_vld = 1'b1;
    tick;
    wdt = 32'h2222_0001;
    tick;
    wdt_vld = 1'b0;
    chk("overrun_err", 64'(err_o), 64'(1));
    wdt = 32'h3333_0002; wdt_vld = 1'b1;
    tick;
    wdt_vld = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 20) begin tick; n++; end
    chk("overrun_done", 64'(done_cnt - d0), 64'(1));
    chk("overrun_err_end", 64'(err_o), 64'(1));
    chk("overrun_mem0", 64'(mem[16'h0300]), 64'h1111_0000);
    chk("overrun_mem1", 64'(mem[16'h0301]), 64'h3333_0002);

    // Start pulse while busy must not disturb the transfer.
    run_xfer(1'b0, 16'h0040, 16'd3, 0, 4, 1'b1);

    // Core write passes through the mux and lands in memory.
    core_req = 1'b1; core_we = 1'b1; core_addr = 16'h8000; core_wdt = 32'hDEAD_BEEF;
    ref_mem[16'h8000] = 32'hDEAD_BEEF;
    tick;
    core_req = 1'b0; core_we = 1'b0;
    tick;
    chk("core_write_mem", 64'(mem[16'h8000]), 64'hDEAD_BEEF);

    // Randomized transfers with core contention.
    for (int t = 0; t < 30; t++) begin
      logic [AW-1:0] ra;
      ra = ($urandom_range(3) == 0) ? (16'hFFFF - 16'($urandom_range(3))) : 16'($urandom);
      run_xfer(1'($urandom_range(1)), ra, 16'($urandom_range(6)),
               int'($urandom_range(40)), int'($urandom_range(3)), 1'b0);
    end

    tick;
    chk("final_rd_queue", 64'(exp_rd.size()), 64'(0));
    chk("final_wr_queue", 64'(exp_wr.size()), 64'(0));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
